// File: rtl/rotate_reader.sv
// Frame-buffer reader for a portrait image window on a 1344x806 raster.
// Generates raster-order read addresses, double-buffer swap control and a latency-aligned pixel stream.
module rotate_reader #(
  parameter int X_OFFSET     = 392,
  parameter int Y_OFFSET     = 224,
  parameter int IMG_W        = 240,
  parameter int IMG_H        = 320,
  parameter int READ_LATENCY = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic [15:0] pixel_in,
  input  logic        swap_req_in,
  output logic [16:0] pixel_addr_out,
  output logic        buffer_sel_out,
  output logic        swap_ack_out,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out,
  output logic [15:0] pixel_out,
  output logic        in_window_out
);

  localparam int          DEPTH    = READ_LATENCY + 2;
  localparam logic [16:0] ADDR_MAX = 17'(IMG_W * IMG_H - 1);
  localparam logic [11:0] X_LO     = 12'(X_OFFSET);
  localparam logic [11:0] X_HI     = 12'(X_OFFSET + IMG_W);
  localparam logic [10:0] Y_LO     = 11'(Y_OFFSET);
  localparam logic [10:0] Y_HI     = 11'(Y_OFFSET + IMG_H);

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    ACTIVE    = 2'd1,
    SWAP_PEND = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic        frame_start_s;
  logic        in_range_s;
  logic        win_s;
  logic        do_swap_s;
  logic [16:0] addr_cnt_r;
  logic [16:0] cur_addr_s;
  logic        buf_sel_r;
  logic        swap_ack_r;
  logic [10:0] h_pipe_r [DEPTH];
  logic [9:0]  v_pipe_r [DEPTH];
  logic [DEPTH-1:0] win_pipe_r;
  logic [15:0] pixel_r;

  assign frame_start_s = (hcount_in == 11'd0) && (vcount_in == 10'd0);
  assign in_range_s    = ({1'b0, hcount_in} >= X_LO) && ({1'b0, hcount_in} < X_HI) &&
                         ({1'b0, vcount_in} >= Y_LO) && ({1'b0, vcount_in} < Y_HI);
  // The frame-start cycle itself already belongs to the synchronised frame.
  assign win_s         = in_range_s && ((state_r != WAIT_SYNC) || frame_start_s);
  assign cur_addr_s    = frame_start_s ? 17'd0 : addr_cnt_r;

  // State register
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_r <= WAIT_SYNC;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      WAIT_SYNC: begin
        if (frame_start_s) state_nxt_s = ACTIVE;
        else               state_nxt_s = WAIT_SYNC;
      end
      ACTIVE: begin
        if (swap_req_in && !frame_start_s) state_nxt_s = SWAP_PEND;
        else                               state_nxt_s = ACTIVE;
      end
      SWAP_PEND: begin
        if (frame_start_s) state_nxt_s = ACTIVE;
        else               state_nxt_s = SWAP_PEND;
      end
      default: state_nxt_s = WAIT_SYNC;
    endcase
  end

  // Output decode: a swap fires only on a frame-start cycle
  always_comb begin
    do_swap_s = 1'b0;
    case (state_r)
      ACTIVE:    do_swap_s = frame_start_s && swap_req_in;
      SWAP_PEND: do_swap_s = frame_start_s;
      default:   do_swap_s = 1'b0;
    endcase
  end

  // Buffer select toggle and acknowledge pulse
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      buf_sel_r  <= 1'b0;
      swap_ack_r <= 1'b0;
    end else begin
      swap_ack_r <= do_swap_s;
      if (do_swap_s) buf_sel_r <= ~buf_sel_r;
      else           buf_sel_r <= buf_sel_r;
    end
  end

  // Raster address counter, saturating at the last image pixel
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      addr_cnt_r     <= 17'd0;
      pixel_addr_out <= 17'd0;
    end else if (win_s) begin
      pixel_addr_out <= cur_addr_s;
      addr_cnt_r     <= (cur_addr_s == ADDR_MAX) ? ADDR_MAX : cur_addr_s + 17'd1;
    end else begin
      addr_cnt_r     <= cur_addr_s;
    end
  end

  // Delay line aligning counts and window flag with the returned read data
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        h_pipe_r[i] <= 11'd0;
        v_pipe_r[i] <= 10'd0;
      end
      win_pipe_r <= {DEPTH{1'b0}};
      pixel_r    <= 16'h0000;
    end else begin
      h_pipe_r[0] <= hcount_in;
      v_pipe_r[0] <= vcount_in;
      for (int i = 1; i < DEPTH; i++) begin
        h_pipe_r[i] <= h_pipe_r[i-1];
        v_pipe_r[i] <= v_pipe_r[i-1];
      end
      win_pipe_r <= {win_pipe_r[DEPTH-2:0], win_s};
      pixel_r    <= win_pipe_r[DEPTH-2] ? pixel_in : 16'h0000;
    end
  end

  assign buffer_sel_out = buf_sel_r;
  assign swap_ack_out   = swap_ack_r;
  assign hcount_out     = h_pipe_r[DEPTH-1];
  assign vcount_out     = v_pipe_r[DEPTH-1];
  assign in_window_out  = win_pipe_r[DEPTH-1];
  assign pixel_out      = pixel_r;

endmodule

// File: tb/tb_rotate_reader.sv
// Bench for rotate_reader: randomized raster samples against a counting/queue model,
// plus a full image pass, swap scenarios and saturation.
module tb_rotate_reader;

  localparam int X0 = 392;
  localparam int Y0 = 224;
  localparam int IW = 240;
  localparam int IH = 320;
  localparam int AMAX = IW * IH - 1;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic [15:0] pixel_in;
  logic        swap_req_in;
  logic [16:0] pixel_addr_out;
  logic        buffer_sel_out;
  logic        swap_ack_out;
  logic [10:0] hcount_out;
  logic [9:0]  vcount_out;
  logic [15:0] pixel_out;
  logic        in_window_out;

  always #5 clk_in = ~clk_in;

  rotate_reader dut (
    .clk_in(clk_in), .rst_in(rst_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .pixel_in(pixel_in), .swap_req_in(swap_req_in), .pixel_addr_out(pixel_addr_out),
    .buffer_sel_out(buffer_sel_out), .swap_ack_out(swap_ack_out), .hcount_out(hcount_out),
    .vcount_out(vcount_out), .pixel_out(pixel_out), .in_window_out(in_window_out)
  );

  // Frame-buffer model: data = address, two-cycle read latency
  logic [16:0] bram_d1, bram_d2;
  always @(posedge clk_in) begin
    bram_d1 <= pixel_addr_out;
    bram_d2 <= bram_d1;
  end
  assign pixel_in = bram_d2[15:0];

  // Reference model state
  bit m_sync, m_pend, m_buf;
  int m_cnt;
  int e_addr;
  bit e_ack;
  int hh[4], hv[4], hp[4];
  bit hw[4];
  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // One raster sample: drive, clock, then advance the model
  task automatic cyc(input int h, input int v, input bit req, input bit rst = 1'b1);
    bit fs, inr, w, sw;
    int a;
    hcount_in = 11'(h);
    vcount_in = 10'(v);
    swap_req_in = req;
    rst_in = rst;
    fs  = (h == 0) && (v == 0);
    inr = (h >= X0) && (h < X0 + IW) && (v >= Y0) && (v < Y0 + IH);
    w   = inr && (m_sync || fs);
    a   = fs ? 0 : m_cnt;
    sw  = fs && (m_pend || (m_sync && req));
    @(posedge clk_in);
    #1;
    if (!rst) begin
      m_sync = 1'b0; m_pend = 1'b0; m_buf = 1'b0; m_cnt = 0; e_addr = 0; e_ack = 1'b0;
      for (int i = 0; i < 4; i++) begin
        hh[i] = 0; hv[i] = 0; hp[i] = 0; hw[i] = 1'b0;
      end
    end else begin
      if (w) begin
        e_addr = a;
        m_cnt = (a == AMAX) ? AMAX : a + 1;
      end else begin
        m_cnt = a;
      end
      e_ack = sw;
      if (sw) begin
        m_buf = !m_buf;
        m_pend = 1'b0;
      end else if (m_sync && req && !fs) begin
        m_pend = 1'b1;
      end
      if (fs) m_sync = 1'b1;
      for (int i = 3; i > 0; i--) begin
        hh[i] = hh[i-1]; hv[i] = hv[i-1]; hp[i] = hp[i-1]; hw[i] = hw[i-1];
      end
      hh[0] = h; hv[0] = v; hw[0] = w; hp[0] = w ? (a & 16'hFFFF) : 0;
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk_in) begin
    if (chk_en) begin
      check("addr", pixel_addr_out, e_addr);
      check("addr_bound", pixel_addr_out <= 17'(AMAX), 1'b1);
      check("buf_sel", buffer_sel_out, m_buf);
      check("swap_ack", swap_ack_out, e_ack);
      check("hcount_out", hcount_out, hh[3]);
      check("vcount_out", vcount_out, hv[3]);
      check("in_window", in_window_out, hw[3]);
      check("pixel_out", pixel_out, hp[3]);
    end
  end

  initial begin
    int r;
    // Reset while the raster is mid-frame, release at (500,300)
    cyc(498, 300, 1'b0, 1'b0);
    chk_en = 1'b1;
    cyc(499, 300, 1'b0, 1'b0);
    check("rst_addr", pixel_addr_out, 17'd0);
    check("rst_buf", buffer_sel_out, 1'b0);
    check("rst_ack", swap_ack_out, 1'b0);
    check("rst_pix", pixel_out, 16'h0000);
    check("rst_win", in_window_out, 1'b0);
    check("rst_hout", hcount_out, 11'd0);
    for (int v = 300; v < 302; v++) begin
      for (int h = (v == 300) ? 500 : 380; h < 640; h++) cyc(h, v, 1'b1);
    end
    check("unsync_addr", pixel_addr_out, 17'd0);
    check("unsync_buf", buffer_sel_out, 1'b0);

    // Randomized raster samples with occasional frame starts and swap requests
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 2) cyc(0, 0, ($urandom_range(0, 3) == 0));
      else cyc($urandom_range(380, 640), $urandom_range(218, 550), ($urandom_range(0, 19) == 0));
    end

    // Mid-frame one-cycle request swaps at the next frame start
    cyc(0, 0, 1'b0, 1'b0);
    cyc(0, 0, 1'b0);
    for (int h = 392; h < 400; h++) cyc(h, 224, 1'b0);
    cyc(400, 230, 1'b1);
    for (int h = 401; h < 410; h++) cyc(h, 230, 1'b0);
    check("swap_wait_buf", buffer_sel_out, 1'b0);
    cyc(0, 0, 1'b0);
    check("swap_buf", buffer_sel_out, 1'b1);
    check("swap_ack", swap_ack_out, 1'b1);
    cyc(5, 5, 1'b0);
    check("swap_ack_end", swap_ack_out, 1'b0);
    // Request held on the frame-start cycle swaps there
    cyc(100, 100, 1'b0);
    cyc(0, 0, 1'b1);
    check("fs_swap_buf", buffer_sel_out, 1'b0);
    check("fs_swap_ack", swap_ack_out, 1'b1);
    cyc(10, 10, 1'b0);
    check("fs_swap_ack_end", swap_ack_out, 1'b0);
    // Reset drops a pending swap
    cyc(50, 50, 1'b1);
    cyc(51, 50, 1'b0, 1'b0);
    cyc(0, 0, 1'b0);
    cyc(1, 1, 1'b0);
    check("rst_drop_buf", buffer_sel_out, 1'b0);
    check("rst_drop_ack", swap_ack_out, 1'b0);

    // Full image pass with literal pins
    cyc(0, 0, 1'b0);
    for (int v = Y0; v < Y0 + IH; v++) begin
      for (int h = X0 - 1; h <= X0 + IW; h++) begin
        cyc(h, v, 1'b0);
        if (v == 224 && h == 394) check("first_win_early", in_window_out, 1'b0);
        if (v == 224 && h == 395) begin
          check("first_win", in_window_out, 1'b1);
          check("first_h", hcount_out, 11'd392);
          check("first_v", vcount_out, 10'd224);
          check("first_pix", pixel_out, 16'h0000);
        end
        if (v == 225 && h == 392) check("line_step0", pixel_addr_out, 17'd240);
        if (v == 225 && h == 393) check("line_step1", pixel_addr_out, 17'd241);
      end
    end
    cyc(700, 543, 1'b0);
    cyc(701, 543, 1'b0);
    check("last_win", in_window_out, 1'b1);
    check("last_h", hcount_out, 11'd631);
    check("last_v", vcount_out, 10'd543);
    check("last_pix", pixel_out, 16'h2BFF);

    // Window revisited without a frame start: counter must saturate
    for (int v = Y0; v < Y0 + 2; v++) begin
      for (int h = X0 - 1; h <= X0 + IW; h++) cyc(h, v, 1'b0);
    end
    check("sat_addr", pixel_addr_out, 17'd76799);
    for (int n = 0; n < 6; n++) cyc(700, 600, 1'b0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rotate_reader.md
ROTATE_READER -- requirements
Module: rotate_reader

Interface
REQ-001 Parameter X_OFFSET, default 392, display column of image left edge.
REQ-002 Parameter Y_OFFSET, default 224, display row of image top edge.
REQ-003 Parameter IMG_W, default 240, image width in pixels; IMG_H, default 320, image height in lines.
REQ-004 Parameter READ_LATENCY, default 2, frame-buffer read latency in cycles.
REQ-005 clk_in  input  1  single 65 MHz clock; all logic SHALL be on its rising edge.
REQ-006 rst_in  input  1  reset, synchronous, active-low.
REQ-007 hcount_in  input  11  display column, 0..1343.
REQ-008 vcount_in  input  10  display row, 0..805.
REQ-009 pixel_in  input  16  RGB565 frame-buffer read data, valid READ_LATENCY cycles after pixel_addr_out.
REQ-010 swap_req_in  input  1  level request to switch to the other frame buffer.
REQ-011 pixel_addr_out  output  17  frame-buffer read address, raster order (row*IMG_W + col).
REQ-012 buffer_sel_out  output  1  selected frame buffer, 0 or 1.
REQ-013 swap_ack_out  output  1  one-cycle pulse when a swap takes effect.
REQ-014 hcount_out  output  11, vcount_out  output  10  hcount_in/vcount_in delayed to align with pixel_out.
REQ-015 pixel_out  output  16  image pixel, or 16'h0000 outside window.
REQ-016 in_window_out  output  1  high when pixel_out carries image data.

Function
REQ-017 Frame start SHALL be the cycle with hcount_in==0 and vcount_in==0.
REQ-018 Window SHALL be X_OFFSET <= hcount_in < X_OFFSET+IMG_W and Y_OFFSET <= vcount_in < Y_OFFSET+IMG_H.
REQ-019 FSM states SHALL be WAIT_SYNC, ACTIVE, SWAP_PEND.
REQ-020 WAIT_SYNC -> ACTIVE on frame start; in WAIT_SYNC window SHALL be treated as false.
REQ-021 ACTIVE -> SWAP_PEND when swap_req_in high; SWAP_PEND -> ACTIVE at next frame start, toggling buffer_sel_out and pulsing swap_ack_out in the following cycle.
REQ-022 swap_req_in high on a frame-start cycle in ACTIVE SHALL swap at that frame start (no extra frame wait).
REQ-023 swap_req_in deasserted while in SWAP_PEND SHALL NOT cancel the pending swap.
REQ-024 Address counter SHALL clear to 0 at frame start and increment by 1 after each in-window cycle; no multiplier.
REQ-025 Address counter SHALL saturate at IMG_W*IMG_H-1 (76799) and never wrap.
REQ-026 pixel_addr_out SHALL be registered: one cycle after an in-window sample it SHALL equal that sample's address; outside window it SHALL hold its last value.
REQ-027 hcount_out, vcount_out, in_window_out, pixel_out SHALL appear exactly READ_LATENCY+2 cycles (4 by default) after the corresponding hcount_in/vcount_in sample.
REQ-028 pixel_out SHALL equal pixel_in captured for an in-window sample, else 16'h0000.
REQ-029 buffer_sel_out SHALL change only at frame start so no frame mixes buffers.

Reset
REQ-030 While rst_in low: state WAIT_SYNC, address 0, pixel_addr_out 0, buffer_sel_out 0, swap_ack_out 0, pixel_out 0, in_window_out 0, hcount_out 0, vcount_out 0, delay pipeline cleared.
REQ-031 Reset asserted mid-frame SHALL discard any pending swap; after release no in_window_out until the next frame start plus 4 cycles.

Verification
REQ-032 Reset then full frame with BRAM model (data=address) -> first in_window_out at (392,224) 4 cycles after that sample, pixel_out 0x0000; last at (631,543), pixel_out 76799 truncated to 16 bits (0x2BFF).
REQ-033 Line step: sample (392,225) -> pixel_addr_out 240 one cycle later; (393,225) -> 241.
REQ-034 swap_req_in pulsed one cycle mid-frame -> buffer_sel_out 0->1 and single swap_ack_out pulse right after next frame start; frame before swap uses buffer 0 throughout.
REQ-035 swap_req_in held high on frame-start cycle -> swap at that frame start, one ack.
REQ-036 Release reset at (500,300) -> no in_window_out and pixel_addr_out stays 0 until following frame; then REQ-032 values.
REQ-037 X_OFFSET=0, Y_OFFSET=0, window extended past image by driving out-of-range counts -> pixel_addr_out never exceeds 76799.
